// File: rtl/reg_dump_text_writer_if.sv
// Text-buffer write port of the register dump writer.
// Handshake: the master holds txt_addr/txt_data stable with txt_we high
// until a cycle where txt_ready is also high; that cycle is the one transfer.
interface reg_dump_text_writer_if #(
   parameter int TXT_AW = 13
) ();
   logic [TXT_AW-1:0] txt_addr;
   logic [7:0]        txt_data;
   logic              txt_we;
   logic              txt_ready;

   modport master (
      output txt_addr,
      output txt_data,
      output txt_we,
      input  txt_ready
   );

   modport slave (
      input  txt_addr,
      input  txt_data,
      input  txt_we,
      output txt_ready
   );
endinterface

// File: rtl/reg_dump_text_writer.sv
// Register dump text writer: walks the register file through a one-cycle
// latency read port and writes each register as upper-case hex ASCII into
// the VGA text buffer, followed by a PC marker column character.
// Optional build macro REG_DUMP_LABEL_EN adds an "Rnn:" label before the hex
// digits of every row.
module reg_dump_text_writer #(
   parameter int NUM_REGS   = 32,
   parameter int DATA_W     = 32,
   parameter int COLS       = 80,
   parameter int TXT_AW     = 13,
   parameter int ROW_BASE   = 2,
   parameter int COL_BASE   = 10,
   parameter int MARKER_COL = 28,
   parameter int REG_AW     = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [31:0]            pc,
   output logic                   busy,
   output logic                   done,
   output logic [REG_AW-1:0]      reg_addr,
   input  logic [DATA_W-1:0]      reg_data,
   reg_dump_text_writer_if.master txt,
   output logic [2:0]             dbg_state_o
);

   localparam int DIGITS = DATA_W / 4;
   // Digit counter also counts the 4 label characters, so keep at least 2 bits.
   localparam int D_W    = (DIGITS > 4) ? $clog2(DIGITS) : 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_CAPT,
`ifdef REG_DUMP_LABEL_EN
      ST_LABEL,
`endif
      ST_DIGIT,
      ST_MARK,
      ST_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [REG_AW-1:0]   idx_q, idx_d;
   logic [D_W-1:0]      d_q, d_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [31:0]         mark_q, mark_d;

   logic [TXT_AW-1:0]   row_addr;
   logic [3:0]          nibble;
   logic [7:0]          hex_char;
`ifdef REG_DUMP_LABEL_EN
   logic [REG_AW-1:0]   tens;
   logic [REG_AW-1:0]   ones;
`endif

   assign dbg_state_o = 3'(state_q);

   // State and datapath registers; reset also abandons any in-flight write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         d_q     <= '0;
         data_q  <= '0;
         mark_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         d_q     <= d_d;
         data_q  <= data_d;
         mark_q  <= mark_d;
      end
   end

   // Character helpers: row start address, current hex digit (MSB first).
   always_comb begin
      row_addr = (TXT_AW'(ROW_BASE) + TXT_AW'(idx_q)) * TXT_AW'(COLS);
      nibble   = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (D_W'(DIGITS - 1 - i) == d_q) begin
            nibble = data_q[i*4 +: 4];
         end
      end
      if (nibble < 4'd10) begin
         hex_char = 8'h30 + {4'h0, nibble};
      end else begin
         hex_char = 8'h37 + {4'h0, nibble};
      end
`ifdef REG_DUMP_LABEL_EN
      tens = idx_q / REG_AW'(10);
      ones = idx_q % REG_AW'(10);
`endif
   end

   // Next-state and output decode; outputs freeze while a write is stalled.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      d_d          = d_q;
      data_d       = data_q;
      mark_d       = mark_q;
      busy         = (state_q != ST_IDLE);
      done         = 1'b0;
      reg_addr     = '0;
      txt.txt_we   = 1'b0;
      txt.txt_addr = '0;
      txt.txt_data = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mark_d  = pc >> 2;
               idx_d   = '0;
               state_d = ST_ADDR;
            end
         end

         ST_ADDR: begin
            reg_addr = idx_q;
            state_d  = ST_CAPT;
         end

         ST_CAPT: begin
            // Register 0 is architecturally zero whatever the port returns.
            data_d = (idx_q == '0) ? '0 : reg_data;
            d_d    = '0;
`ifdef REG_DUMP_LABEL_EN
            state_d = ST_LABEL;
`else
            state_d = ST_DIGIT;
`endif
         end

`ifdef REG_DUMP_LABEL_EN
         ST_LABEL: begin
            txt.txt_we   = 1'b1;
            txt.txt_addr = row_addr + TXT_AW'(COL_BASE - 4) + TXT_AW'(d_q);
            case (d_q[1:0])
               2'd0:    txt.txt_data = 8'h52;
               2'd1:    txt.txt_data = 8'h30 + 8'(tens);
               2'd2:    txt.txt_data = 8'h30 + 8'(ones);
               default: txt.txt_data = 8'h3A;
            endcase
            if (txt.txt_ready) begin
               if (d_q == D_W'(3)) begin
                  d_d     = '0;
                  state_d = ST_DIGIT;
               end else begin
                  d_d = d_q + D_W'(1);
               end
            end
         end
`endif

         ST_DIGIT: begin
            txt.txt_we   = 1'b1;
            txt.txt_addr = row_addr + TXT_AW'(COL_BASE) + TXT_AW'(d_q);
            txt.txt_data = hex_char;
            if (txt.txt_ready) begin
               if (d_q == D_W'(DIGITS - 1)) begin
                  d_d     = '0;
                  state_d = ST_MARK;
               end else begin
                  d_d = d_q + D_W'(1);
               end
            end
         end

         ST_MARK: begin
            txt.txt_we   = 1'b1;
            txt.txt_addr = row_addr + TXT_AW'(MARKER_COL);
            // An out-of-range PC index never matches, so no row is marked.
            txt.txt_data = (mark_q == 32'(idx_q)) ? 8'h7F : 8'h20;
            if (txt.txt_ready) begin
               if (idx_q == REG_AW'(NUM_REGS - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + REG_AW'(1);
                  state_d = ST_ADDR;
               end
            end
         end

         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_reg_dump_text_writer.sv
// Bench for reg_dump_text_writer: randomized register contents and
// back-pressure, checked against a write-list model built from the rules.
module tb_reg_dump_text_writer;

   localparam int NUM_REGS   = 32;
   localparam int DATA_W     = 32;
   localparam int COLS       = 80;
   localparam int TXT_AW     = 13;
   localparam int ROW_BASE   = 2;
   localparam int COL_BASE   = 10;
   localparam int MARKER_COL = 28;
   localparam int REG_AW     = 5;
   localparam int DIGITS     = DATA_W / 4;
`ifdef REG_DUMP_LABEL_EN
   localparam int PER        = 7 + DIGITS;
   localparam int LIT_DONE   = 481;
`else
   localparam int PER        = 3 + DIGITS;
   localparam int LIT_DONE   = 353;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [31:0]       pc_in = '0;
   logic              busy, done;
   logic [REG_AW-1:0] reg_addr;
   logic [DATA_W-1:0] reg_data = '0;
   logic [2:0]        dbg_state;

   always #5 clk = ~clk;

   reg_dump_text_writer_if #(.TXT_AW(TXT_AW)) txt_bus ();

   reg_dump_text_writer #(
      .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .COLS(COLS), .TXT_AW(TXT_AW),
      .ROW_BASE(ROW_BASE), .COL_BASE(COL_BASE), .MARKER_COL(MARKER_COL),
      .REG_AW(REG_AW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pc(pc_in),
      .busy(busy), .done(done), .reg_addr(reg_addr), .reg_data(reg_data),
      .txt(txt_bus.master), .dbg_state_o(dbg_state)
   );

   // Register file with one-cycle read latency.
   logic [DATA_W-1:0] rf [NUM_REGS];
   always @(posedge clk) reg_data <= rf[reg_addr];

   // ---------------- scoreboard ----------------
   logic [TXT_AW+7:0] exp_q[$];
   logic [7:0]        txt_mem [1 << TXT_AW];
   int                total = 0;
   int                bad = 0;
   int                stall_cnt = 0;
   int                ready_mode = 0;
   int                last_done = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] hex_ch(input int n);
      return (n < 10) ? 8'(8'h30 + n) : 8'(8'h41 + n - 10);
   endfunction

   // Expected write list for one dump, in issue order.
   task automatic build_model(input logic [31:0] pcv);
      logic [31:0]       mark;
      logic [DATA_W-1:0] v;
      int                row;
      exp_q.delete();
      mark = pcv >> 2;
      for (int i = 0; i < NUM_REGS; i++) begin
         v   = (i == 0) ? '0 : rf[i];
         row = (ROW_BASE + i) * COLS;
`ifdef REG_DUMP_LABEL_EN
         exp_q.push_back({TXT_AW'(row + COL_BASE - 4), 8'h52});
         exp_q.push_back({TXT_AW'(row + COL_BASE - 3), 8'(8'h30 + i / 10)});
         exp_q.push_back({TXT_AW'(row + COL_BASE - 2), 8'(8'h30 + i % 10)});
         exp_q.push_back({TXT_AW'(row + COL_BASE - 1), 8'h3A});
`endif
         for (int k = 0; k < DIGITS; k++) begin
            exp_q.push_back({TXT_AW'(row + COL_BASE + k),
                             hex_ch(int'((v >> (4 * (DIGITS - 1 - k))) & 'hF))});
         end
         exp_q.push_back({TXT_AW'(row + MARKER_COL), (mark == 32'(i)) ? 8'h7F : 8'h20});
      end
   endtask

   // Ready driver: constant, random, or the repeating 1,0,0,1 pattern.
   initial begin
      int pat_i;
      pat_i = 0;
      txt_bus.txt_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1: txt_bus.txt_ready = 1'($urandom_range(0, 1));
            2: begin
               txt_bus.txt_ready = (pat_i == 0 || pat_i == 3);
               pat_i = (pat_i + 1) % 4;
            end
            default: txt_bus.txt_ready = 1'b1;
         endcase
      end
   end

   // Compare process: every accepted write against the model, and hold
   // stability across stalled cycles.
   initial begin
      logic [TXT_AW+7:0] hold;
      logic [TXT_AW+7:0] got;
      bit                hold_valid;
      hold_valid = 1'b0;
      hold = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_valid = 1'b0;
         end else begin
            got = {txt_bus.txt_addr, txt_bus.txt_data};
            if (hold_valid) begin
               check("stall_we_held", 32'(txt_bus.txt_we), 32'd1);
               check("stall_write_held", 32'(got), 32'(hold));
            end
            if (txt_bus.txt_we) begin
               if (txt_bus.txt_ready) begin
                  hold_valid = 1'b0;
                  if (exp_q.size() == 0) begin
                     check("unexpected_write", 32'(got), 32'h0);
                  end else begin
                     check("write", 32'(got), 32'(exp_q.pop_front()));
                  end
                  txt_mem[txt_bus.txt_addr] = txt_bus.txt_data;
               end else begin
                  hold = got;
                  hold_valid = 1'b1;
                  stall_cnt++;
               end
            end else begin
               hold_valid = 1'b0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic run_dump(input logic [31:0] pcv, input bit second_start);
      int cyc;
      int busy_low;
      bit got;
      build_model(pcv);
      stall_cnt = 0;
      @(posedge clk);
      #1 start = 1'b1;
      pc_in = pcv;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 0;
      got = 1'b0;
      busy_low = 0;
      while (!got && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (second_start && cyc == 40) begin
            start = 1'b1;
            pc_in = 32'h4;
         end
         if (second_start && cyc == 41) start = 1'b0;
         if (!busy) busy_low++;
         if (done) got = 1'b1;
      end
      if (!got) begin
         check("done_timeout", 32'd0, 32'd1);
      end else begin
         check("done_cycle", 32'(cyc), 32'(NUM_REGS * PER + 1 + stall_cnt));
      end
      last_done = cyc;
      check("busy_during_dump", 32'(busy_low), 32'd0);
      check("all_writes_seen", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      check("busy_after_done", 32'(busy), 32'd0);
      check("done_one_cycle", 32'(done), 32'd0);
   endtask

   task automatic randomize_rf();
      for (int i = 0; i < NUM_REGS; i++) rf[i] = $urandom;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      string s;
      bit    found;
      int    n;
      randomize_rf();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_we", 32'(txt_bus.txt_we), 32'd0);
      check("rst_addr", 32'(txt_bus.txt_addr), 32'd0);
      check("rst_data", 32'(txt_bus.txt_data), 32'd0);
      check("rst_reg_addr", 32'(reg_addr), 32'd0);

      // Directed dump with hand-computed expectations.
      rf[0]  = 32'hFFFF_FFFF;
      rf[5]  = 32'hDEAD_BEEF;
      rf[31] = 32'h0000_0001;
      ready_mode = 0;
      run_dump(32'h0000_000C, 1'b0);
      check("lit_done_cycle", 32'(last_done), 32'(LIT_DONE));
      s = "DEADBEEF";
      for (int i = 0; i < 8; i++) check("lit_deadbeef", 32'(txt_mem[7*80 + 10 + i]), 32'(s[i]));
      for (int i = 0; i < 8; i++) check("lit_reg0_zero", 32'(txt_mem[2*80 + 10 + i]), 32'h30);
      s = "00000001";
      for (int i = 0; i < 8; i++) check("lit_reg31", 32'(txt_mem[33*80 + 10 + i]), 32'(s[i]));
`ifdef REG_DUMP_LABEL_EN
      s = "R31:";
      for (int i = 0; i < 4; i++) check("lit_label31", 32'(txt_mem[33*80 + 6 + i]), 32'(s[i]));
`endif
      for (int i = 0; i < NUM_REGS; i++) begin
         check("lit_marker", 32'(txt_mem[(2 + i)*80 + 28]), (i == 3) ? 32'h7F : 32'h20);
      end

      // Back-pressure with the 1,0,0,1 pattern.
      randomize_rf();
      ready_mode = 2;
      run_dump(32'($urandom_range(0, NUM_REGS - 1)) << 2, 1'b0);

      // Random back-pressure and random PC.
      randomize_rf();
      ready_mode = 1;
      run_dump($urandom, 1'b0);

      // PC index out of range: every marker is a space.
      randomize_rf();
      ready_mode = 0;
      run_dump(32'h0000_0400, 1'b0);
      for (int i = 0; i < NUM_REGS; i++) check("lit_no_marker", 32'(txt_mem[(2 + i)*80 + 28]), 32'h20);

      // Start pulsed while busy must be ignored.
      randomize_rf();
      ready_mode = 1;
      run_dump(32'h0000_0010, 1'b1);

      // Reset in the middle of a DIGIT write.
      ready_mode = 0;
      randomize_rf();
      build_model(32'h0000_0008);
      @(posedge clk);
      #1 start = 1'b1;
      pc_in = 32'h0000_0008;
      @(posedge clk);
      #1 start = 1'b0;
      found = 1'b0;
      n = 0;
      while (!found && n < 600) begin
         @(negedge clk);
         n++;
         if (txt_bus.txt_we && txt_bus.txt_addr == TXT_AW'((ROW_BASE + 2) * COLS + COL_BASE + 3))
            found = 1'b1;
      end
      check("reach_mid_digit", 32'(found), 32'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_we", 32'(txt_bus.txt_we), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);

      // Fresh full dump after the reset.
      randomize_rf();
      ready_mode = 1;
      run_dump($urandom, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
